// File: rtl/t2t_msg_decoder.sv
// t2t_msg_decoder: reassembles 3-beat Avalon-ST market-data packets and emits one
// {symid, price, volume} record per well-formed packet whose type matches
// MSG_TYPE_MATCH. Non-matching, runt, oversize and stray traffic is discarded.
// Optional build macro T2T_DEC_STATS_EN adds saturating drop_cnt / err_cnt outputs.
`timescale 1ns/1ps

module t2t_msg_decoder #(
    parameter logic [23:0] MSG_TYPE_MATCH = 24'h4E4557
`ifdef T2T_DEC_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef T2T_DEC_STATS_EN
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt,
`endif
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_symid,
    output logic [63:0]      out_price,
    output logic [31:0]      out_volume
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT2 = 2'd1,
        S_BEAT3 = 2'd2,
        S_SKIP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_sop_nxt;
    logic        w_fire;
    logic        w_start;
    logic        w_type_ok;
    logic        w_lat_b1;
    logic        w_lat_b2;
    logic        w_load;
    logic [15:0] r_symid;
    logic [23:0] r_price_up;
    logic [39:0] r_price_dn;
    logic [23:0] r_vol_up;

    // The output register can always take a new record when it is empty or retiring.
    assign in_ready  = ~out_valid | out_ready;
    assign w_fire    = in_valid & in_ready;
    assign w_start   = in_sop & ~in_eop;
    assign w_type_ok = (in_data[63:40] == MSG_TYPE_MATCH);

    // FSM state register; a reset mid-packet simply abandons the partial packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and latch strobes; any sop beat restarts framing identically in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_b1    = 1'b0;
        w_lat_b2    = 1'b0;
        w_load      = 1'b0;
        w_sop_nxt   = w_start ? (w_type_ok ? S_BEAT2 : S_SKIP) : S_IDLE;
        if (w_fire) begin
            if (in_sop) begin
                w_state_nxt = w_sop_nxt;
                w_lat_b1    = w_start;
            end else begin
                case (r_state)
                    S_IDLE: w_state_nxt = S_IDLE;
                    S_BEAT2: begin
                        if (in_eop) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_lat_b2    = 1'b1;
                            w_state_nxt = S_BEAT3;
                        end
                    end
                    S_BEAT3: begin
                        if (in_eop) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (in_eop) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Staging latches for beat1/beat2 fields; stale contents are never used without a fresh beat1.
    always_ff @(posedge clk) begin
        if (w_lat_b1) begin
            r_symid    <= in_data[39:24];
            r_price_up <= in_data[23:0];
        end
        if (w_lat_b2) begin
            r_price_dn <= in_data[63:24];
            r_vol_up   <= in_data[23:0];
        end
    end

    // Output record register: a load on the same edge as a retire replaces it with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_symid  <= '0;
            out_price  <= '0;
            out_volume <= '0;
        end else if (w_load) begin
            out_valid  <= 1'b1;
            out_symid  <= r_symid;
            out_price  <= {r_price_up, r_price_dn};
            out_volume <= {r_vol_up, in_data[63:56]};
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef T2T_DEC_STATS_EN
    logic w_drop;
    logic w_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Drop: an accepted packet start whose type does not match.
    // Err: stray beat, runt (sop+eop or eop on beat2), restart inside BEAT2/BEAT3, oversize.
    assign w_drop = w_fire & w_start & ~w_type_ok;
    assign w_err  = w_fire & ((in_sop & in_eop)
                            | (in_sop & ((r_state == S_BEAT2) | (r_state == S_BEAT3)))
                            | (~in_sop & (r_state == S_IDLE))
                            | (~in_sop & in_eop & (r_state == S_BEAT2))
                            | (~in_sop & ~in_eop & (r_state == S_BEAT3)));

    // Saturating event counters, at most one increment each per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (w_drop) drop_cnt <= sat_inc(drop_cnt);
            if (w_err)  err_cnt  <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_t2t_msg_decoder.sv
// Self-checking bench for t2t_msg_decoder: table-driven packets plus hand-written
// framing, backpressure, streaming and reset sequences, checked by a record scoreboard.
// Counter checks are active when T2T_DEC_STATS_EN is defined.
`timescale 1ns/1ps

module tb_t2t_msg_decoder;
    localparam logic [23:0] NEW_T = 24'h4E4557;
    localparam logic [23:0] OLD_T = 24'h4F4C44;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_symid;
    logic [63:0] out_price;
    logic [31:0] out_volume;
`ifdef T2T_DEC_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
`endif

    t2t_msg_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef T2T_DEC_STATS_EN
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt),
`endif
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symid  (out_symid),
        .out_price  (out_price),
        .out_volume (out_volume)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] symid;
        logic [63:0] price;
        logic [31:0] volume;
    } rec_t;

    typedef struct {
        logic [23:0] typ;
        logic [15:0] symid;
        logic [63:0] price;
        logic [31:0] volume;
    } vec_t;

    rec_t expq[$];
    int   rt_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e_err = 0;
    int   e_drop = 0;
    bit   rec_rt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string name);
`ifdef T2T_DEC_STATS_EN
        chk(name, 128'(err_cnt), 128'(e_err));
`endif
    endtask

    task automatic chk_drop(input string name);
`ifdef T2T_DEC_STATS_EN
        chk(name, 128'(drop_cnt), 128'(e_drop));
`endif
    endtask

    // Drive one beat from a falling edge and hold it until the rising edge that accepts it.
    task automatic beat(input logic sop, input logic eop, input logic [63:0] d);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        #1;
        w = 0;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            w++;
            if (w > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, required 1", w);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Packet builder plus reference model: matching types produce a record, others a drop.
    task automatic send_pkt(input logic [23:0] typ, input logic [15:0] sym,
                            input logic [63:0] pr, input logic [31:0] vol);
        rec_t r;
        if (typ == NEW_T) begin
            r.symid  = sym;
            r.price  = pr;
            r.volume = vol;
            expq.push_back(r);
        end else begin
            e_drop++;
        end
        beat(1'b1, 1'b0, {typ, sym, pr[63:40]});
        beat(1'b0, 1'b0, {pr[39:0], vol[31:8]});
        beat(1'b0, 1'b1, {vol[7:0], 56'h0});
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (expq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk(name, 128'(expq.size()), 128'd0);
    endtask

    // Output monitor: scoreboard on each retire, stability while stalled.
    initial begin : mon
        rec_t        e;
        logic [111:0] held;
        bit          stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid) begin
                if (stalled) chk("stall_stable", 128'({out_symid, out_price, out_volume}), 128'(held));
                held    = {out_symid, out_price, out_volume};
                stalled = !out_ready;
                if (out_ready) begin
                    if (rec_rt) rt_q.push_back(cyc);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_record: got symid %0h, required no record", out_symid);
                    end else begin
                        e = expq.pop_front();
                        chk("rec_symid", 128'(out_symid), 128'(e.symid));
                        chk("rec_price", 128'(out_price), 128'(e.price));
                        chk("rec_volume", 128'(out_volume), 128'(e.volume));
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish after 1 ms, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[6];
        rec_t r;
        tbl[0] = '{NEW_T,    16'h1234, 64'h0102030405060708, 32'hCAFEBABE};
        tbl[1] = '{OLD_T,    16'h0001, 64'h1111111111111111, 32'h22222222};
        tbl[2] = '{NEW_T,    16'hFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF};
        tbl[3] = '{24'h4E4556, 16'h0BAD, 64'hDEADBEEFDEADBEEF, 32'h0000_0001};
        tbl[4] = '{NEW_T,    16'h0000, 64'h0000000000000000, 32'h00000000};
        tbl[5] = '{NEW_T,    16'hA5A5, 64'h8000000000000001, 32'h80000001};

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_symid", 128'(out_symid), 128'd0);
        chk("rst_price", 128'(out_price), 128'd0);
        chk("rst_volume", 128'(out_volume), 128'd0);
        chk_err("rst_err_cnt");
        chk_drop("rst_drop_cnt");
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // Reference NEW packet with raw beats and one-cycle latency
        r.symid  = 16'h0042;
        r.price  = 64'h123456789ABCDEF0;
        r.volume = 32'h00010203;
        expq.push_back(r);
        beat(1'b1, 1'b0, 64'h4E4557_0042_123456);
        beat(1'b0, 1'b0, 64'h789ABCDEF0_000102);
        #1;
        chk("pre_b3_out_valid", 128'(out_valid), 128'd0);
        beat(1'b0, 1'b1, 64'h03_00000000000000);
        #1;
        chk("latency_out_valid", 128'(out_valid), 128'd1);
        idle();
        drain("drain_basic");

        // Non-matching type
        send_pkt(OLD_T, 16'h0042, 64'h1, 32'h2);
        idle();
        drain("drain_old");
        chk_drop("drop_after_old");

        // Runt: eop on beat2
        beat(1'b1, 1'b0, {NEW_T, 16'h0007, 24'h111111});
        beat(1'b0, 1'b1, 64'h2222222222_333333);
        e_err++;
        idle();
        drain("drain_runt");
        chk_err("err_after_runt");

        // Restart mid-BEAT3, then a full packet: only the second one is emitted
        beat(1'b1, 1'b0, {NEW_T, 16'h0008, 24'h444444});
        beat(1'b0, 1'b0, 64'h5555555555_666666);
        e_err++;
        send_pkt(NEW_T, 16'h0009, 64'h0123456789ABCDEF, 32'h13579BDF);
        idle();
        drain("drain_restart");
        chk_err("err_after_restart");

        // Oversize packet goes to SKIP until eop; next packet decodes
        beat(1'b1, 1'b0, {NEW_T, 16'h000A, 24'h777777});
        beat(1'b0, 1'b0, 64'h8888888888_999999);
        beat(1'b0, 1'b0, 64'hAA00000000000000);
        e_err++;
        beat(1'b0, 1'b0, {NEW_T, 16'hBEEF, 24'h0});
        beat(1'b0, 1'b1, 64'hBB00000000000000);
        send_pkt(NEW_T, 16'h000B, 64'hFEDCBA9876543210, 32'h89ABCDEF);
        idle();
        drain("drain_oversize");
        chk_err("err_after_oversize");

        // Stray beat and sop+eop runt in IDLE
        beat(1'b0, 1'b1, {NEW_T, 16'h000C, 24'h0});
        e_err++;
        beat(1'b1, 1'b1, {NEW_T, 16'h000D, 24'h0});
        e_err++;
        idle();
        drain("drain_stray");
        chk_err("err_after_stray");

        // Table-driven packets, back to back
        for (int i = 0; i < 6; i++) send_pkt(tbl[i].typ, tbl[i].symid, tbl[i].price, tbl[i].volume);
        idle();
        drain("drain_table");
        chk_drop("drop_after_table");
        chk_err("err_after_table");

        // sop inside SKIP restarts framing
        beat(1'b1, 1'b0, {OLD_T, 16'h000E, 24'h0});
        e_drop++;
        send_pkt(NEW_T, 16'h000F, 64'h0F0F0F0F0F0F0F0F, 32'hF0F0F0F0);
        idle();
        drain("drain_skip_restart");
        chk_drop("drop_after_skip_restart");

        // Backpressure: two packets while downstream stalls
        out_ready = 1'b0;
        fork
            begin
                send_pkt(NEW_T, 16'h0101, 64'hAAAA5555AAAA5555, 32'h01010101);
                send_pkt(NEW_T, 16'h0202, 64'h5555AAAA5555AAAA, 32'h02020202);
                idle();
            end
            begin
                repeat (10) @(negedge clk);
                #1;
                chk("bp_in_ready_low", 128'(in_ready), 128'd0);
                chk("bp_out_valid_held", 128'(out_valid), 128'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Ten back-to-back packets at full rate
        rt_q.delete();
        rec_rt = 1'b1;
        for (int i = 0; i < 10; i++)
            send_pkt(NEW_T, 16'(16'h0300 + i), {32'h5A5A0000, 32'(i)}, 32'(32'h00A00000 + i));
        idle();
        drain("drain_stream");
        rec_rt = 1'b0;
        chk("stream_count", 128'(rt_q.size()), 128'd10);
        for (int i = 1; i < rt_q.size(); i++) chk("stream_spacing", 128'(rt_q[i] - rt_q[i-1]), 128'd3);

        // Reset while a record is held clears out_valid at once
        out_ready = 1'b0;
        send_pkt(NEW_T, 16'h0400, 64'h4, 32'h4);
        idle();
        repeat (2) @(negedge clk);
        chk("held_before_reset", 128'(out_valid), 128'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 128'(out_valid), 128'd0);
        expq.delete();
        e_err  = 0;
        e_drop = 0;
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // Reset mid-beat2: partial packet discarded
        beat(1'b1, 1'b0, {NEW_T, 16'h0500, 24'h0});
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 64'h1234;
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_b2_reset_out_valid", 128'(out_valid), 128'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_err("err_after_reset");
        beat(1'b0, 1'b1, 64'h0500000000000000);
        e_err++;
        send_pkt(NEW_T, 16'h0600, 64'h6666777788889999, 32'h0A0B0C0D);
        idle();
        drain("drain_post_reset");
        chk_err("err_post_reset");
        chk_drop("drop_post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
